// File: rtl/multi_rate_fifo_pkg.sv
// Shared types and helpers for the multi-rate FIFO slice (package fifo_types).
// Holds the debug status encoding and the modulo index helper used by the
// storage array so every lane computes its address the same way.

package fifo_types;

   // Coarse occupancy status, used only for debug/status encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2
   } fifo_status_e;

   // Index of (ptr + offset) wrapped into a 2**ptrWidth deep circular store
   function automatic int wrap_idx(input int ptr, input int offset, input int ptrWidth);
      return (ptr + offset) & ((1 << ptrWidth) - 1);
   endfunction

   // Debug helper: classify an occupancy value against the storage depth
   function automatic fifo_status_e status_of(input int count, input int capacity);
      if (count == 0) begin
         return IDLE;
      end else if (count >= capacity) begin
         return FULL;
      end
      return ACTIVE;
   endfunction

endpackage

// File: rtl/multi_rate_fifo_storage.sv
// fifo_storage_mem: CAP_P x WIDTH circular word store with a WRITE_SIZE-lane
// write port and a READ_SIZE-lane combinational read port. Every lane address
// is wrapped modulo the depth, so windows may straddle the last index.

module fifo_storage_mem
   import fifo_types::*;
#(
   parameter int WIDTH      = 16,
   parameter int PTR_WIDTH  = 8,
   parameter int WRITE_SIZE = 1,
   parameter int READ_SIZE  = 1
) (
   input  logic                                clk_i,
   input  logic                                we_i,
   input  logic [PTR_WIDTH-1:0]                wrPtr_i,
   input  logic [WRITE_SIZE-1:0][WIDTH-1:0]    data_i,
   input  logic [PTR_WIDTH-1:0]                rdPtr_i,
   output logic [READ_SIZE-1:0][WIDTH-1:0]     data_o
);

   localparam int CAP_P = 1 << PTR_WIDTH;

   logic [WIDTH-1:0] mem_q [CAP_P];

   // Write all lanes of an accepted enqueue into consecutive wrapped slots
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < WRITE_SIZE; i++) begin
            mem_q[PTR_WIDTH'(wrap_idx(32'(wrPtr_i), i, PTR_WIDTH))] <= data_i[i];
         end
      end
   end

   // Present the head window starting at the read pointer (fall-through)
   always_comb begin
      data_o = '0;
      for (int i = 0; i < READ_SIZE; i++) begin
         data_o[i] = mem_q[PTR_WIDTH'(wrap_idx(32'(rdPtr_i), i, PTR_WIDTH))];
      end
   end

endmodule

// File: rtl/multi_rate_fifo.sv
// multi_rate_fifo: circular FIFO that accepts WRITE_SIZE words per enqueue
// and presents/removes READ_SIZE words per dequeue. An explicit occupancy
// counter handles ratios that do not divide each other; leftover words stay
// at the head and merge with later enqueues in order.
// Default widths come from the he_headers.sv macros BIT_WIDTH, WRITE_SIZE and
// READ_SIZE; fallbacks are provided below when those are not defined.
// Optional feature: define MULTI_RATE_FIFO_FLUSH_EN to add flush_i, which
// empties the FIFO (rd_ptr = wr_ptr, count = 0) without touching storage.

`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef WRITE_SIZE
`define WRITE_SIZE 4
`endif
`ifndef READ_SIZE
`define READ_SIZE 2
`endif

module multi_rate_fifo
   import fifo_types::*;
#(
   parameter int WIDTH      = `BIT_WIDTH,
   parameter int WRITE_SIZE = `WRITE_SIZE,
   parameter int READ_SIZE  = `READ_SIZE,
   parameter int PTR_WIDTH  = 8
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
`ifdef MULTI_RATE_FIFO_FLUSH_EN
   input  logic                              flush_i,
`endif
   input  logic [WRITE_SIZE-1:0][WIDTH-1:0]  data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output logic                              valid_o,
   output logic [READ_SIZE-1:0][WIDTH-1:0]   data_o,
   input  logic                              yumi_i,
   output logic [PTR_WIDTH:0]                count_o
);

   localparam int CAP_P = 1 << PTR_WIDTH;
   localparam int CNT_W = PTR_WIDTH + 1;

   // Occupancy thresholds and per-transaction step sizes in counter width
   localparam logic [CNT_W-1:0] W_CNT    = CNT_W'(WRITE_SIZE);
   localparam logic [CNT_W-1:0] R_CNT    = CNT_W'(READ_SIZE);
   localparam logic [CNT_W-1:0] MAX_FILL = CNT_W'(CAP_P - WRITE_SIZE);

   logic [PTR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic flushNow;
   logic spaceOk;
   logic dataOk;
   logic enq;
   logic deq;

   // Handshake: ready/valid depend only on the registered count, forced low
   // while reset (or a flush) is being applied so nothing is accepted then
   always_comb begin
`ifdef MULTI_RATE_FIFO_FLUSH_EN
      flushNow = flush_i;
`else
      flushNow = 1'b0;
`endif
      spaceOk = (count_q <= MAX_FILL);
      dataOk  = (count_q >= R_CNT);
      ready_o = spaceOk & ~reset_i & ~flushNow;
      valid_o = dataOk & ~reset_i & ~flushNow;
      count_o = reset_i ? '0 : count_q;
      enq     = valid_i & ready_o;
      deq     = yumi_i & valid_o;
   end

   // Next-state: advance pointers by their window sizes, update occupancy;
   // a flush collapses the read pointer onto the write pointer
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q + (enq ? W_CNT : '0) - (deq ? R_CNT : '0);
      if (enq) begin
         wrPtr_d = wrPtr_q + PTR_WIDTH'(WRITE_SIZE);
      end
      if (deq) begin
         rdPtr_d = rdPtr_q + PTR_WIDTH'(READ_SIZE);
      end
      if (flushNow) begin
         rdPtr_d = wrPtr_q;
         wrPtr_d = wrPtr_q;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   fifo_storage_mem #(
      .WIDTH      (WIDTH),
      .PTR_WIDTH  (PTR_WIDTH),
      .WRITE_SIZE (WRITE_SIZE),
      .READ_SIZE  (READ_SIZE)
   ) storage (
      .clk_i   (clk_i),
      .we_i    (enq),
      .wrPtr_i (wrPtr_q),
      .data_i  (data_i),
      .rdPtr_i (rdPtr_q),
      .data_o  (data_o)
   );

endmodule

// File: doc/multi_rate_fifo.md
Name: multi_rate_fifo

Overview:
- Parametrised successor of the single-buffer param_fifo.
- Circular FIFO that accepts WRITE_SIZE words per enqueue and presents READ_SIZE words per dequeue.
- Supports arbitrary (non-divisible) write/read ratios through an explicit occupancy counter.
- Sits between HE coefficient producers and consumers that run at different vector widths, e.g. NTT stage and polynomial multiplier.

Parameters:
- WIDTH, `BIT_WIDTH: bits per word.
- WRITE_SIZE, `WRITE_SIZE: words accepted per enqueue; 1 <= WRITE_SIZE <= CAP_P.
- READ_SIZE, `READ_SIZE: words presented and removed per dequeue; 1 <= READ_SIZE <= CAP_P.
- PTR_WIDTH, 8: address bits.
- CAP_P, 1<<PTR_WIDTH: storage depth in words; derived, not to be overridden.

Ports:
- clk_i  in  1  clock; one clock domain.
- reset_i  in  1  synchronous, active-high reset.
- data_i  in  [WRITE_SIZE][WIDTH]  enqueue words; data_i[0] is oldest.
- valid_i  in  1  producer valid.
- ready_o  out  1  space for WRITE_SIZE words.
- valid_o  out  1  at least READ_SIZE words stored.
- data_o  out  [READ_SIZE][WIDTH]  head words; data_o[0] is oldest.
- yumi_i  in  1  consumer takes data_o; legal only while valid_o=1.
- count_o  out  PTR_WIDTH+1  words currently stored.

Behaviour:
- State: rd_ptr and wr_ptr (PTR_WIDTH bits each, wrap modulo CAP_P), count (PTR_WIDTH+1 bits), storage of CAP_P words.
- Reset (synchronous, reset_i=1 at a clk_i edge): rd_ptr=0, wr_ptr=0, count=0; storage contents are don't-care.
- While reset_i=1: ready_o=0, valid_o=0, count_o=0. The cycle after deassertion: ready_o=1, valid_o=0.
- ready_o = (CAP_P - count >= WRITE_SIZE). valid_o = (count >= READ_SIZE). Both are combinational from registered count only; no dependence on valid_i or yumi_i.
- enq = valid_i & ready_o. deq = yumi_i & valid_o.
- Enqueue: mem[(wr_ptr+i) mod CAP_P] <= data_i[i] for i in 0..WRITE_SIZE-1; wr_ptr += WRITE_SIZE (mod CAP_P).
- Dequeue: rd_ptr += READ_SIZE (mod CAP_P).
- count_next = count + WRITE_SIZE*enq - READ_SIZE*deq.
- data_o[i] = mem[(rd_ptr+i) mod CAP_P], combinational (first-word-fall-through). Contents are undefined while valid_o=0.
- Latency: a word written at edge N is visible on data_o at N+1 if the occupancy rule allows. There is no same-cycle bypass.
- Simultaneous enq+deq: both take effect. ready_o uses pre-dequeue count, so a full FIFO rejects the write even while being read.
- Partial residue: fewer than READ_SIZE words leaves valid_o=0. Residual words stay at the head and combine with the next enqueue in order.
- yumi_i while valid_o=0: ignored, no state change. Bench flags it as a protocol error.
- valid_i while ready_o=0: ignored; the producer must hold data_i.
- Wrap-around: an enqueue or dequeue window may straddle index CAP_P-1 to 0; index arithmetic is modulo CAP_P.
- Reset mid-traffic: the in-flight enqueue or dequeue on the reset edge is discarded.

Optional Feature:
- Macro MULTI_RATE_FIFO_FLUSH_EN.
- When defined, adds port flush_i (in, 1). flush_i=1 at a clock edge sets rd_ptr=wr_ptr and count=0, and drops any simultaneous enq/deq. ready_o=0 and valid_o=0 during the flush cycle. Storage is untouched.
- When undefined, there is no port and no flush logic.

Decomposition:
- Package fifo_types holds:
  - typedefs for the handshake state enum {IDLE, ACTIVE, FULL}, used for the debug status encoding only;
  - a function wrap_idx(ptr, offset) returning the modulo-CAP_P index.
- Default constants come from he_headers.sv.
- One sub-module, fifo_storage_mem: CAP_P x WIDTH array with a WRITE_SIZE-lane write port and READ_SIZE-lane combinational read port, indexed through wrap_idx.

Test Plan (WIDTH=16, PTR_WIDTH=4, CAP_P=16):
- Reset: W=4,R=2; hold reset_i 2 cycles with valid_i=1 -> ready_o=0, valid_o=0 during reset; after release ready_o=1, count_o=0, no write taken.
- Order: W=4,R=2; enqueue {1,2,3,4} -> next cycle valid_o=1, data_o={0x0001,0x0002}; yumi -> data_o={0x0003,0x0004}, count_o=2.
- Full: W=4,R=2; 4 enqueues -> count_o=16, ready_o=0. Then valid_i=1,yumi_i=1 -> write rejected, count_o=14, ready_o=0 until count<=12.
- Residue: W=3,R=2; enqueue {A,B,C}, yumi -> count_o=1, valid_o=0. Enqueue {D,E,F} -> data_o={C,D}.
- Wrap: W=3,R=2; stream 40 words with random stalls -> output sequence equals input sequence and windows cross index 15->0.
- Flush (MULTI_RATE_FIFO_FLUSH_EN): count_o=6, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, ready_o=1.
